// File: rtl/mem_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_io_responder_pkg
// Shared definitions for the memory/IO responder: the I/O address map, the
// I/O-space select value and the run/stop state encodings.
// ---------------------------------------------------------------------------
package mem_io_responder_pkg;

  // Upper two address bits that select I/O space instead of RAM
  localparam logic [1:0]  IO_SPACE_SEL  = 2'b11;

  // UART data register: write pushes a TX byte, read pops an RX byte
  localparam logic [17:0] IO_DATA_ADDR  = 18'h30000;

  // Cycle counter / stop register: reads of +0..+3 return counter bytes,
  // a write to +0 requests program stop
  localparam logic [17:0] IO_CYCLE_ADDR = 18'h30004;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_HALTED   = 2'd2
  } run_state_e;

  // Little-endian byte select out of a 32-bit word
  function automatic logic [7:0] word_byte(input logic [31:0] word,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_responder_ram_bank.sv
// ---------------------------------------------------------------------------
// ram_bank
// Synchronous single-port byte RAM with a registered read port.
// Ports:
//   clk     - clock
//   wr_en   - write enable, write happens at the rising edge
//   addr    - byte address
//   wdata   - write data
//   rdata   - read data for the address of the previous cycle
// Contents are deliberately not reset so a CPU reset keeps RAM intact.
// ---------------------------------------------------------------------------
module ram_bank
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem_q [2**ADDR_WIDTH];
  logic [7:0] rdata_q;

  // Read-first: a read during a write returns the old contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// CPU-side memory and I/O responder: RAM, UART TX FIFO, UART RX pass-through,
// free-running cycle counter with snapshot, and a run/stop/halt controller.
// Ports:
//   clk_in, rst_in     - clock, synchronous active-low reset
//   mem_a/mem_dout/mem_wr - CPU address, write data, write strobe
//   mem_din            - registered read data (address of previous cycle)
//   io_buffer_full     - TX FIFO nearly full
//   tx_data/tx_valid/tx_ready - UART transmit handshake
//   rx_data/rx_valid/rx_ready - UART receive handshake
//   halt               - program has stopped and TX has drained
// ---------------------------------------------------------------------------
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(TX_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FIFO_NEAR_CNT = CNT_W'(TX_FIFO_DEPTH - FULL_MARGIN);

  logic [17:0] addr;
  logic        io_sel;
  logic        data_hit;
  logic        cycle_hit;
  logic        stop_hit;
  logic        rd_cycle;
  logic        unused_mem_a;

  logic [7:0]  ram_rdata;
  logic        ram_wr_en;

  logic [7:0]  fifo_mem_q [TX_FIFO_DEPTH];
  logic [7:0]  fifo_mem_d [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        push_req;
  logic [7:0]  push_byte;
  logic        stop_req;
  logic        push;
  logic        pop;
  logic        fifo_full;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic [7:0]  io_rdata_q, io_rdata_d;
  logic        rd_io_q, rd_io_d;
  logic        rd_valid_q;

  run_state_e  state_q, state_d;

  // Address decode; only the low 18 address bits take part
  assign addr         = mem_a[17:0];
  assign io_sel       = (addr[17:16] == IO_SPACE_SEL);
  assign data_hit     = (addr == IO_DATA_ADDR);
  assign cycle_hit    = (addr[17:2] == IO_CYCLE_ADDR[17:2]);
  assign stop_hit     = (addr == IO_CYCLE_ADDR);
  assign rd_cycle     = !mem_wr;
  assign unused_mem_a = ^mem_a[31:18];

  assign ram_wr_en = rst_in && mem_wr && !io_sel;

  ram_bank #(
    .ADDR_WIDTH(RAM_ADDR_WIDTH)
  ) u_ram_bank (
    .clk   (clk_in),
    .wr_en (ram_wr_en),
    .addr  (mem_a[RAM_ADDR_WIDTH-1:0]),
    .wdata (mem_dout),
    .rdata (ram_rdata)
  );

  // FIFO status and the UART transmit side of the handshake
  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_mem_q[rd_ptr_q];
  assign fifo_full      = (count_q == FIFO_FULL_CNT);
  assign io_buffer_full = (count_q >= FIFO_NEAR_CNT);
  assign pop            = tx_valid && tx_ready;

  // RX byte is consumed only in the cycle the CPU actually reads it
  assign rx_ready = rst_in && rd_cycle && data_hit && rx_valid;

  assign halt = (state_q == ST_HALTED);

  // Bytes queued for transmit: nonzero data writes, and a 0x00 marker
  // written when the program asks to stop
  always_comb begin
    push_req  = 1'b0;
    push_byte = 8'h00;
    stop_req  = 1'b0;
    if (mem_wr && io_sel) begin
      if (data_hit && (mem_dout != 8'h00)) begin
        push_req  = 1'b1;
        push_byte = mem_dout;
      end else if (stop_hit) begin
        push_req  = 1'b1;
        push_byte = 8'h00;
        stop_req  = 1'b1;
      end
    end
  end

  // A push into a full FIFO is only taken when a pop frees the slot in the
  // same cycle, so the count never exceeds the depth
  assign push = push_req && (!fifo_full || pop);

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // I/O read data, captured for return on the following cycle; reading the
  // counter's low byte also freezes the whole word for the upper-byte reads
  always_comb begin
    io_rdata_d = 8'h00;
    snapshot_d = snapshot_q;
    rd_io_d    = io_sel;
    cycle_d    = cycle_q + 32'd1;
    if (rd_cycle && io_sel) begin
      if (data_hit) begin
        io_rdata_d = rx_valid ? rx_data : 8'h00;
      end else if (cycle_hit) begin
        if (addr[1:0] == 2'd0) begin
          io_rdata_d = cycle_q[7:0];
          snapshot_d = cycle_q;
        end else begin
          io_rdata_d = word_byte(snapshot_q, addr[1:0]);
        end
      end
    end
  end

  // Halt waits until every queued byte, including the stop marker, is gone
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if ((count_q == '0) && !push) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      snapshot_q <= '0;
      io_rdata_q <= 8'h00;
      rd_io_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      snapshot_q <= snapshot_d;
      io_rdata_q <= io_rdata_d;
      rd_io_q    <= rd_io_d;
      rd_valid_q <= 1'b1;
      state_q    <= state_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_in) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // Returned data is forced to zero until the first post-reset read
  assign mem_din = !rd_valid_q ? 8'h00 :
                   (rd_io_q ? io_rdata_q : ram_rdata);

endmodule

// File: tb/tb_mem_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_io_responder
// Directed bench for mem_io_responder with a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_mem_io_responder;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halt;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model state
  logic [7:0]  m_txq [$];
  logic [7:0]  m_ram [int];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  bit          m_stop;
  bit          m_halt;
  logic [7:0]  m_din;
  bit          m_din_known;
  bit          m_live = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .halt           (halt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one CPU cycle; returns 1 time unit after the sampling edge
  task automatic applyStimulus(input logic [31:0] a, input logic wr,
                               input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyReset();
    rst_in = 1'b0;
    applyStimulus(32'h0, 1'b0, 8'h00);
    rst_in = 1'b1;
  endtask

  // Behavioural model: advanced once per rising edge from the inputs the
  // DUT sees at that edge
  task automatic modelStep();
    logic [17:0] a;
    bit          io, pop, push, accepted, stop_now, known;
    logic [7:0]  pb, nd;
    int          sz;
    if (!rst_in) begin
      m_txq.delete();
      m_cnt       = 32'h0;
      m_snap      = 32'h0;
      m_stop      = 0;
      m_halt      = 0;
      m_din       = 8'h00;
      m_din_known = 1;
      m_live      = 1;
      return;
    end
    a        = mem_a[17:0];
    io       = (a[17:16] == 2'b11);
    sz       = m_txq.size();
    pop      = (sz > 0) && tx_ready;
    push     = 0;
    pb       = 8'h00;
    stop_now = 0;
    nd       = 8'h00;
    known    = 1;
    if (mem_wr) begin
      known = 0;
      if (io) begin
        if (a == 18'h30000 && mem_dout != 8'h00) begin
          push = 1;
          pb   = mem_dout;
        end else if (a == 18'h30004) begin
          push     = 1;
          pb       = 8'h00;
          stop_now = 1;
        end
      end else begin
        m_ram[int'(a[16:0])] = mem_dout;
      end
    end else if (io) begin
      case (a)
        18'h30000: nd = rx_valid ? rx_data : 8'h00;
        18'h30004: begin nd = m_cnt[7:0]; m_snap = m_cnt; end
        18'h30005: nd = m_snap[15:8];
        18'h30006: nd = m_snap[23:16];
        18'h30007: nd = m_snap[31:24];
        default:   nd = 8'h00;
      endcase
    end else begin
      known = m_ram.exists(int'(a[16:0]));
      nd    = known ? m_ram[int'(a[16:0])] : 8'h00;
    end
    accepted = push && ((sz < 16) || pop);
    if (pop) void'(m_txq.pop_front());
    if (accepted) m_txq.push_back(pb);
    if (m_stop && !m_halt && sz == 0 && !accepted) m_halt = 1;
    if (stop_now) m_stop = 1;
    m_cnt       = m_cnt + 32'd1;
    m_din       = nd;
    m_din_known = known;
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      modelStep();
    end
  end

  // Compare process: all outputs against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk_in);
      if (m_live) begin
        checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, m_txq.size() != 0});
        if (m_txq.size() != 0) checkOutput("tx_data", {24'd0, tx_data}, {24'd0, m_txq[0]});
        checkOutput("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, m_txq.size() >= 14});
        checkOutput("halt", {31'd0, halt}, {31'd0, m_halt});
        if (m_din_known) checkOutput("mem_din", {24'd0, mem_din}, {24'd0, m_din});
        checkOutput("rx_ready", {31'd0, rx_ready},
                    {31'd0, rst_in && !mem_wr && (mem_a[17:0] == 18'h30000) && rx_valid});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset_halt", {31'd0, halt}, 32'd0);
    checkOutput("reset_full", {31'd0, io_buffer_full}, 32'd0);
    checkOutput("reset_mem_din", {24'd0, mem_din}, 32'd0);
    rst_in = 1'b1;

    // RAM write then read with one-cycle latency; upper address bits ignored
    applyStimulus(32'h0000_0010, 1'b1, 8'hA5);
    applyStimulus(32'h0000_0010, 1'b0, 8'h00);
    checkOutput("ram_readback", {24'd0, mem_din}, 32'hA5);
    applyStimulus(32'hABC0_0020, 1'b1, 8'h3C);
    applyStimulus(32'h0000_0020, 1'b0, 8'h00);
    checkOutput("ram_alias", {24'd0, mem_din}, 32'h3C);

    // Fill the TX FIFO with the transmitter stalled
    tx_ready = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(32'h0003_0000, 1'b1, 8'(i));
      if (i == 13) checkOutput("near_full_13", {31'd0, io_buffer_full}, 32'd0);
    end
    checkOutput("near_full_14", {31'd0, io_buffer_full}, 32'd1);
    for (int i = 15; i <= 17; i++) applyStimulus(32'h0003_0000, 1'b1, 8'(i));
    checkOutput("model_count_full", m_txq.size(), 32'd16);

    // Push and pop together while full: count stays 16
    tx_ready = 1'b1;
    applyStimulus(32'h0003_0000, 1'b1, 8'h55);
    checkOutput("model_count_swap", m_txq.size(), 32'd16);
    checkOutput("full_after_swap", {31'd0, io_buffer_full}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      checkOutput("drain_byte", {24'd0, tx_data}, (k < 15) ? 32'(k + 2) : 32'h55);
      applyStimulus(32'h0, 1'b0, 8'h00);
    end
    checkOutput("drained", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Zero byte is not queued; other I/O addresses have no effect
    applyStimulus(32'h0003_0000, 1'b1, 8'h00);
    checkOutput("zero_ignored", {31'd0, tx_valid}, 32'd0);
    applyStimulus(32'h0003_0008, 1'b1, 8'h66);
    applyStimulus(32'h0003_0001, 1'b1, 8'h66);
    checkOutput("other_io_write", {31'd0, tx_valid}, 32'd0);
    applyStimulus(32'h0003_0008, 1'b0, 8'h00);
    checkOutput("other_io_read", {24'd0, mem_din}, 32'd0);

    // RX read with and without a byte waiting
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    mem_a    = 32'h0003_0000;
    mem_wr   = 1'b0;
    #2;
    checkOutput("rx_ready_pulse", {31'd0, rx_ready}, 32'd1);
    @(posedge clk_in);
    #1;
    checkOutput("rx_byte", {24'd0, mem_din}, 32'hC3);
    rx_valid = 1'b0;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    checkOutput("rx_empty", {24'd0, mem_din}, 32'd0);

    // Cycle counter snapshot, little-endian
    force dut.cycle_q = 32'h1234_5678;
    m_cnt = 32'h1234_5678;
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    release dut.cycle_q;
    checkOutput("cnt_b0", {24'd0, mem_din}, 32'h78);
    applyStimulus(32'h0003_0005, 1'b0, 8'h00);
    checkOutput("cnt_b1", {24'd0, mem_din}, 32'h56);
    applyStimulus(32'h0003_0006, 1'b0, 8'h00);
    checkOutput("cnt_b2", {24'd0, mem_din}, 32'h34);
    applyStimulus(32'h0003_0007, 1'b0, 8'h00);
    checkOutput("cnt_b3", {24'd0, mem_din}, 32'h12);
    applyReset();

    // Stop sequence: 'A', stop marker, drain, then sticky halt
    tx_ready = 1'b0;
    applyStimulus(32'h0003_0000, 1'b1, 8'h41);
    applyStimulus(32'h0003_0004, 1'b1, 8'h00);
    checkOutput("stop_halt0", {31'd0, halt}, 32'd0);
    checkOutput("stop_head_A", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("stop_head_0", {24'd0, tx_data}, 32'h00);
    checkOutput("stop_valid_0", {31'd0, tx_valid}, 32'd1);
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("stop_empty", {31'd0, tx_valid}, 32'd0);
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("halt_set", {31'd0, halt}, 32'd1);
    repeat (5) applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("halt_sticky", {31'd0, halt}, 32'd1);
    tx_ready = 1'b0;

    // Reset with a full FIFO: queue discarded, RAM kept, counter restarts
    applyStimulus(32'h0000_1234, 1'b1, 8'h5A);
    for (int i = 0; i < 16; i++) applyStimulus(32'h0003_0000, 1'b1, 8'(8'h80 + i));
    checkOutput("prefill_full", {31'd0, io_buffer_full}, 32'd1);
    applyReset();
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_full", {31'd0, io_buffer_full}, 32'd0);
    checkOutput("rst_halt", {31'd0, halt}, 32'd0);
    checkOutput("rst_mem_din", {24'd0, mem_din}, 32'd0);
    applyStimulus(32'h0000_1234, 1'b0, 8'h00);
    checkOutput("ram_survives_reset", {24'd0, mem_din}, 32'h5A);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("cnt_after_reset", {24'd0, mem_din}, 32'h01);

    repeat (3) applyStimulus(32'h0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
